// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that shares one start/done ALU among NUM_REQ requesters, with a done watchdog.
// Define ALU_ARB_STATS_EN to build the completion and timeout statistics counters.
module alu_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  input  logic [3*NUM_REQ-1:0]   req_op,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [15:0]            rsp_result,
  output logic                   rsp_error,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic [2:0]             alu_op,
  output logic                   alu_start,
  input  logic                   alu_done,
  input  logic [15:0]            alu_result,
  output logic                   busy,
  output logic [15:0]            stat_done_cnt,
  output logic [15:0]            stat_to_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = IDX_W + 1;
  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);
  localparam logic [2:0] OP_NOP = 3'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e           state_q,  state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] win_q,    win_d;
  logic [7:0]       a_q,      a_d;
  logic [7:0]       b_q,      b_d;
  logic [2:0]       op_q,     op_d;
  logic [7:0]       wd_q,     wd_d;
  logic [15:0]      res_q,    res_d;
  logic             err_q,    err_d;

  // Round-robin search: first pending requester at or above rr_ptr, wrapping.
  logic             arb_found;
  logic [IDX_W-1:0] arb_win;
  logic [SUM_W-1:0] arb_cand;
  logic [SUM_W-1:0] ptr_inc;
  logic [2:0]       arb_op;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    arb_found = 1'b0;
    arb_win   = '0;
    arb_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_cand = SUM_W'(rr_ptr_q) + SUM_W'(k);
      if (arb_cand >= SUM_W'(NUM_REQ)) arb_cand = arb_cand - SUM_W'(NUM_REQ);
      if (!arb_found && req_valid[arb_cand[IDX_W-1:0]]) begin
        arb_found = 1'b1;
        arb_win   = arb_cand[IDX_W-1:0];
      end
    end
    ptr_inc = SUM_W'(arb_win) + SUM_W'(1);
    if (ptr_inc == SUM_W'(NUM_REQ)) ptr_inc = '0;
    arb_op = req_op[3*int'(arb_win) +: 3];
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    win_d     = win_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    wd_d      = wd_q;
    res_d     = res_q;
    err_d     = err_q;
    req_ready = '0;

    unique case (state_q)
      IDLE: begin
        if (arb_found) begin
          req_ready = NUM_REQ'(1) << arb_win;
          win_d     = arb_win;
          a_d       = req_a[8*int'(arb_win) +: 8];
          b_d       = req_b[8*int'(arb_win) +: 8];
          op_d      = arb_op;
          rr_ptr_d  = ptr_inc[IDX_W-1:0];
          wd_d      = '0;
          if (arb_op == OP_NOP) begin
            res_d   = '0;
            err_d   = 1'b0;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        wd_d = wd_q + 8'd1;
        // A done arriving on the timeout cycle still counts as success.
        if (alu_done) begin
          res_d   = alu_result;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wd_d == TIMEOUT_W) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        wd_d    = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      wd_q     <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      wd_q     <= wd_d;
      res_q    <= res_d;
      err_q    <= err_d;
    end
  end

  // The RESP cycle doubles as the mandatory start-low gap between operations.
  assign alu_start  = (state_q == ISSUE);
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign busy       = (state_q != IDLE);
  assign rsp_valid  = (state_q == RESP) ? (NUM_REQ'(1) << win_q) : '0;
  assign rsp_result = (state_q == RESP) ? res_q : '0;
  assign rsp_error  = (state_q == RESP) && err_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] done_cnt_q, done_cnt_d;
  logic [15:0] to_cnt_q,   to_cnt_d;

  always_comb begin
    done_cnt_d = done_cnt_q;
    to_cnt_d   = to_cnt_q;
    if (state_q == RESP) begin
      if (err_q) to_cnt_d   = to_cnt_q + 16'd1;
      else       done_cnt_d = done_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      done_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      done_cnt_q <= done_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign stat_done_cnt = done_cnt_q;
  assign stat_to_cnt   = to_cnt_q;
`else
  assign stat_done_cnt = 16'h0;
  assign stat_to_cnt   = 16'h0;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: ALU stub, timeline model of the expected outputs, and directed scenarios.
module tb_alu_req_arbiter;
  localparam int N  = 4;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [8*N-1:0]  req_a, req_b;
  logic [3*N-1:0]  req_op;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [15:0]     rsp_result;
  logic            rsp_error;
  logic [7:0]      alu_a, alu_b;
  logic [2:0]      alu_op;
  logic            alu_start, alu_done, busy;
  logic [15:0]     alu_result, stat_done_cnt, stat_to_cnt;

  always #5 clk = ~clk;

  alu_req_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_error(rsp_error),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .busy(busy),
    .stat_done_cnt(stat_done_cnt), .stat_to_cnt(stat_to_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- ALU stub ----------------
  int   lat_ovr = -1;
  bit   hang    = 0;
  logic spur_done = 1'b0;
  logic stub_done = 1'b0;
  logic [15:0] stub_res = 16'hBAD0;
  bit   act = 0;
  int   left = 0;
  logic [15:0] pend = 16'h0;

  assign alu_done   = stub_done | spur_done;
  assign alu_result = stub_res;

  function automatic int lat_of(input logic [2:0] op);
    return (op >= 3'd1 && op <= 3'd3) ? 1 : 3;
  endfunction

  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      default: return 16'(a) * 16'(b);
    endcase
  endfunction

  always @(posedge clk) begin
    if (alu_start !== 1'b1) begin
      act = 0;
      stub_done <= 1'b0;
      stub_res  <= 16'hBAD0;
    end else begin
      if (!act) begin
        act  = 1;
        left = hang ? 100000 : ((lat_ovr >= 0 ? lat_ovr : lat_of(alu_op)) - 1);
        pend = alu_fn(alu_a, alu_b, alu_op);
      end else if (left > 0) begin
        left--;
      end
      stub_done <= (left == 0);
      stub_res  <= (left == 0) ? pend : 16'hBAD0;
    end
  end

  // ---------------- timeline model ----------------
  // Each grant is followed by m_issue start-high cycles and then one response cycle.
  bit          m_busy = 0;
  int          m_c = 0, m_issue = 0, m_win = 0, m_ptr = 0;
  logic [7:0]  m_a = 0, m_b = 0;
  logic [2:0]  m_op = 0;
  logic [15:0] m_res = 0;
  logic        m_err = 0;
  logic [15:0] m_done_cnt = 0, m_to_cnt = 0;

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  always @(posedge clk) begin
    int w, l;
    if (!reset_n) begin
      m_busy = 0; m_ptr = 0; m_c = 0; m_done_cnt = 0; m_to_cnt = 0;
    end else if (m_busy) begin
      if (m_c == m_issue + 1) begin
        m_busy = 0;
        if (m_err) m_to_cnt++; else m_done_cnt++;
      end else begin
        m_c++;
      end
    end else if (req_valid != '0) begin
      w      = pick(req_valid, m_ptr);
      m_win  = w;
      m_ptr  = (w + 1) % N;
      m_a    = req_a[8*w +: 8];
      m_b    = req_b[8*w +: 8];
      m_op   = req_op[3*w +: 3];
      m_busy = 1;
      m_c    = 1;
      if (m_op == 3'd0) begin
        m_issue = 0; m_res = 0; m_err = 0;
      end else begin
        l = (lat_ovr >= 0) ? lat_ovr : lat_of(m_op);
        if (hang || l + 1 > TO) begin
          m_issue = TO; m_res = 0; m_err = 1;
        end else begin
          m_issue = l + 1; m_res = alu_fn(m_a, m_b, m_op); m_err = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [N-1:0] e_rdy, e_rv;
    logic e_start, e_busy, e_err;
    logic [15:0] e_res;
    int w;
    if (chk_en) begin
      e_rdy = '0; e_rv = '0; e_start = 0; e_busy = 0; e_err = 0; e_res = 0;
      if (!m_busy) begin
        w = pick(req_valid, m_ptr);
        if (w >= 0) e_rdy = N'(1) << w;
      end else if (m_c <= m_issue) begin
        e_start = 1; e_busy = 1;
        check("cmp_alu_a", alu_a, m_a);
        check("cmp_alu_b", alu_b, m_b);
        check("cmp_alu_op", alu_op, m_op);
      end else begin
        e_busy = 1;
        e_rv   = N'(1) << m_win;
        e_res  = m_res;
        e_err  = m_err;
      end
      check("cmp_req_ready", req_ready, e_rdy);
      check("cmp_alu_start", alu_start, e_start);
      check("cmp_busy", busy, e_busy);
      check("cmp_rsp_valid", rsp_valid, e_rv);
      if (e_rv != '0) begin
        check("cmp_rsp_result", rsp_result, e_res);
        check("cmp_rsp_error", rsp_error, e_err);
      end
`ifdef ALU_ARB_STATS_EN
      check("cmp_stat_done", stat_done_cnt, m_done_cnt);
      check("cmp_stat_to", stat_to_cnt, m_to_cnt);
`else
      check("cmp_stat_done", stat_done_cnt, 16'h0);
      check("cmp_stat_to", stat_to_cnt, 16'h0);
`endif
    end
  end

  // ---------------- requester tasks ----------------
  task automatic wait_grant(input int idx, output int g, output bit seen);
    seen = 0; g = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (req_ready[idx]) begin seen = 1; g = cyc; end
      @(posedge clk); #1;
    end
    check("grant_timely", seen, 1);
  endtask

  task automatic run_one(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         output int lat, output logic [15:0] res, output logic err);
    int g;
    bit seen;
    lat = -1; res = 16'hFFFF; err = 1'b0;
    req_a[8*idx +: 8] = a;
    req_b[8*idx +: 8] = b;
    req_op[3*idx +: 3] = op;
    req_valid[idx] = 1'b1;
    wait_grant(idx, g, seen);
    req_valid[idx] = 1'b0;
    seen = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (rsp_valid[idx]) begin seen = 1; lat = cyc - g; res = rsp_result; err = rsp_error; end
    end
    check("rsp_timely", seen, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, g, gi, ng;
    logic [15:0] res;
    logic err;
    bit seen;
    int order[8];

    reset_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_alu_start", alu_start, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_stat_done", stat_done_cnt, 0);
    check("rst_stat_to", stat_to_cnt, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;

    run_one(0, 8'h12, 8'h34, 3'd1, lat, res, err);
    check("add_lat", lat, 3); check("add_res", res, 16'h0046); check("add_err", err, 0);
    run_one(2, 8'hFF, 8'hFF, 3'd4, lat, res, err);
    check("mul_lat", lat, 5); check("mul_res", res, 16'hFE01); check("mul_err", err, 0);
    run_one(1, 8'hAA, 8'h55, 3'd0, lat, res, err);
    check("nop_lat", lat, 1); check("nop_res", res, 16'h0000); check("nop_err", err, 0);
    run_one(3, 8'hF0, 8'h3C, 3'd2, lat, res, err);
    check("and_lat", lat, 3); check("and_res", res, 16'h0030);
    run_one(0, 8'hF0, 8'h3C, 3'd3, lat, res, err);
    check("xor_lat", lat, 3); check("xor_res", res, 16'h00CC);
    run_one(1, 8'h03, 8'h05, 3'd5, lat, res, err);
    check("op5_lat", lat, 5); check("op5_res", res, 16'h000F);

    // done strobe while idle must be ignored
    spur_done = 1'b1;
    repeat (2) @(posedge clk);
    #1 spur_done = 1'b0;
    @(negedge clk);
    check("spur_busy", busy, 0);
    @(posedge clk); #1;

    hang = 1;
    run_one(1, 8'h01, 8'h02, 3'd1, lat, res, err);
    hang = 0;
    check("to_lat", lat, 16); check("to_res", res, 16'h0000); check("to_err", err, 1);
`ifdef ALU_ARB_STATS_EN
    check("to_stat_to", stat_to_cnt, 1); check("to_stat_done", stat_done_cnt, 6);
`else
    check("to_stat_to", stat_to_cnt, 0); check("to_stat_done", stat_done_cnt, 0);
`endif

    lat_ovr = 14;
    run_one(2, 8'h05, 8'h06, 3'd1, lat, res, err);
    check("edge_done_lat", lat, 16); check("edge_done_res", res, 16'h000B); check("edge_done_err", err, 0);
    lat_ovr = 15;
    run_one(3, 8'h05, 8'h06, 3'd1, lat, res, err);
    check("edge_to_lat", lat, 16); check("edge_to_res", res, 16'h0000); check("edge_to_err", err, 1);
    lat_ovr = -1;

    // reset in the middle of a multiply on requester 2
    req_a[16 +: 8] = 8'h07; req_b[16 +: 8] = 8'h09; req_op[6 +: 3] = 3'd4;
    req_valid[2] = 1'b1;
    wait_grant(2, g, seen);
    req_valid[2] = 1'b0;
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_start", alu_start, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rsp", rsp_valid, 0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // all requesters held valid: grants must rotate starting from 0
    for (int i = 0; i < N; i++) begin
      req_a[8*i +: 8] = 8'(16 * i + 1);
      req_b[8*i +: 8] = 8'(i + 2);
      req_op[3*i +: 3] = 3'(1 + (i % 3));
    end
    req_valid = '1;
    ng = 0;
    for (int t = 0; t < 200 && ng < 8; t++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        gi = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) gi = i;
        order[ng] = gi;
        ng++;
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    check("rr_grants", ng, 8);
    for (int i = 0; i < 8; i++) check("rr_order", order[i], i % 4);
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (!busy) seen = 1;
    end
    check("rr_drain", seen, 1);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one ALU (8-bit A/B, 3-bit op, start/done handshake, 16-bit result) between NUM_REQ requesters.
- Performs round-robin arbitration and registers the winner's operands.
- Drives the ALU start/done handshake, including the mandatory start-low gap between operations.
- Returns the result to the winner, with a watchdog that catches a missing done.
- Sits between the requester agents and the ALU core, inside the ALU subsystem.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- TIMEOUT, 15: maximum cycles in ISSUE waiting for alu_done before error completion, 1..255.

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous reset, active-low
- req_valid  input  NUM_REQ  per-requester request pending
- req_a  input  8*NUM_REQ  operand A, requester i at bits [8i+7:8i]
- req_b  input  8*NUM_REQ  operand B, same packing as req_a
- req_op  input  3*NUM_REQ  op, requester i at bits [3i+2:3i]; 0=no_op, 1=add, 2=and, 3=xor, 4=mul
- req_ready  output  NUM_REQ  one-hot accept strobe
- rsp_valid  output  NUM_REQ  one-hot, one-cycle completion pulse
- rsp_result  output  16  result, valid with rsp_valid
- rsp_error  output  1  timeout flag, valid with rsp_valid
- alu_a  output  8  to ALU A
- alu_b  output  8  to ALU B
- alu_op  output  3  to ALU op
- alu_start  output  1  to ALU start
- alu_done  input  1  from ALU done
- alu_result  input  16  from ALU result
- busy  output  1  high when state != IDLE
- stat_done_cnt  output  16  completed-operation counter (optional feature)
- stat_to_cnt  output  16  timeout counter (optional feature)

Behaviour:
- Reset (synchronous, active-low, clk): state=IDLE, rr_ptr=0, all outputs 0, watchdog 0, stat counters 0. Reset mid-operation aborts with no response; alu_start drops on the next edge.
- FSM states: IDLE, ISSUE, RESP.
- IDLE, arbitration:
  - If any req_valid is set, the winner is the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in that cycle; the requester's transfer completes there.
  - On the clock edge, register winner index, A, B and op, and set rr_ptr=(winner+1) mod NUM_REQ.
  - If op==0, go to RESP with result 0, error 0; the ALU is never started. Otherwise go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE:
  - alu_start=1; alu_a, alu_b and alu_op hold the registered values, which are stable for the whole operation.
  - Watchdog increments each cycle.
  - When alu_done is sampled 1: capture alu_result, error=0, go to RESP.
  - Else if watchdog reaches TIMEOUT: result=0, error=1, go to RESP.
  - alu_done takes priority when it coincides with the timeout cycle.
- RESP:
  - alu_start=0, which provides the required start-low gap.
  - rsp_valid[winner]=1 for exactly one cycle with rsp_result and rsp_error.
  - Watchdog clears; next state IDLE.
- alu_done sampled outside ISSUE is ignored.
- Ops 5..7 are forwarded unchanged; the ALU handles them on its multiplier path.
- Latency, measured from the edge that grants: add/and/xor responds 3 cycles later, mul 5, no_op 1. The ALU done latency is 1 cycle for single ops and 3 for mul.
- Throughput:
  - One request per IDLE→…→RESP pass.
  - A requester holding req_valid after its grant is re-arbitrated in the next IDLE at lowest priority.
  - req_valid deasserting during ISSUE/RESP has no effect.
- Widths: rsp_result is passed through unmodified. Counters wrap from 16'hFFFF to 0.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - stat_done_cnt increments on each rsp_valid with rsp_error=0, including no_op.
  - stat_to_cnt increments on each rsp_valid with rsp_error=1.
  - Both counters clear on reset.
- Undefined: both ports are tied to 16'h0 and no counter flops are built.

Test Plan:
- Single add: req 0 with A=8'h12, B=8'h34, op=1, ALU model done after 1 cycle → req_ready[0] pulse; alu_start high for 2 cycles; rsp_valid[0] 3 cycles after grant with rsp_result=16'h0046, rsp_error=0.
- Mul: req 2 with A=8'hFF, B=8'hFF, op=4 → rsp_result=16'hFE01 on rsp_valid[2]; alu_start low in the RESP cycle.
- Round-robin: req 0..3 all held valid for 8 operations → grant order 0,1,2,3,0,1,2,3, one RESP-cycle alu_start gap between each.
- no_op: req 1 with op=0 → alu_start never rises; rsp_valid[1] next cycle with result 0, error 0.
- Timeout: ALU model never asserts done, TIMEOUT=15 → rsp_valid pulse with rsp_error=1 and result 0 after 15 ISSUE cycles; stat_to_cnt=1 with ALU_ARB_STATS_EN.
- Reset mid-ISSUE: reset_n low during a mul → next cycle alu_start=0, busy=0, rr_ptr=0, no rsp_valid.
